// File: rtl/multicycle_control.sv
// Control FSM for a multicycle CPU: instructions take 2-5 cycles, and outputs are combinational from state and inputs.
// IF and the memory states stall while mem_ready is low. num_inst counts retired instructions.
module multicycle_control #(
  parameter int INST_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            opcode,
  input  logic [5:0]            func_code,
  input  logic                  mem_ready,
  input  logic                  bcond,
  output logic                  PCWrite,
  output logic                  IorD,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegDst,
  output logic                  ALUSrcA,
  output logic                  RegWrite,
  output logic                  MemtoReg,
  output logic                  isWWD,
  output logic                  is_halted,
  output logic [1:0]            PCSource,
  output logic [1:0]            ALUSrcB,
  output logic [3:0]            ALUOperation,
  output logic [INST_CNT_W-1:0] num_inst
);

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_LHI = 4'd8;

  localparam logic [3:0] S_IF      = 4'd0;
  localparam logic [3:0] S_ID      = 4'd1;
  localparam logic [3:0] S_EX_R    = 4'd2;
  localparam logic [3:0] S_EX_I    = 4'd3;
  localparam logic [3:0] S_EX_ADDR = 4'd4;
  localparam logic [3:0] S_EX_BR   = 4'd5;
  localparam logic [3:0] S_MEM_RD  = 4'd6;
  localparam logic [3:0] S_MEM_WR  = 4'd7;
  localparam logic [3:0] S_WB_ALU  = 4'd8;
  localparam logic [3:0] S_WB_MEM  = 4'd9;
  localparam logic [3:0] S_HALT    = 4'd10;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       retire;

  logic is_rtype, is_add, is_wwd, is_hlt;
  logic is_adi, is_lhi, is_lwd, is_swd, is_bne, is_jmp;

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_add   = is_rtype && (func_code == FN_ADD);
  assign is_wwd   = is_rtype && (func_code == FN_WWD);
  assign is_hlt   = is_rtype && (func_code == FN_HLT);
  assign is_adi   = (opcode == OP_ADI);
  assign is_lhi   = (opcode == OP_LHI);
  assign is_lwd   = (opcode == OP_LWD);
  assign is_swd   = (opcode == OP_SWD);
  assign is_bne   = (opcode == OP_BNE);
  assign is_jmp   = (opcode == OP_JMP);

  // JMP, WWD and unknown encodings all finish in ID and fall back to IF.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IF: begin
        if (mem_ready) state_nxt = S_ID;
      end
      S_ID: begin
        if (is_add)                 state_nxt = S_EX_R;
        else if (is_adi || is_lhi)  state_nxt = S_EX_I;
        else if (is_lwd || is_swd)  state_nxt = S_EX_ADDR;
        else if (is_bne)            state_nxt = S_EX_BR;
        else if (is_hlt)            state_nxt = S_HALT;
        else                        state_nxt = S_IF;
      end
      S_EX_R:    state_nxt = S_WB_ALU;
      S_EX_I:    state_nxt = S_WB_ALU;
      S_EX_ADDR: state_nxt = is_lwd ? S_MEM_RD : S_MEM_WR;
      S_EX_BR:   state_nxt = S_IF;
      S_MEM_RD: begin
        if (mem_ready) state_nxt = S_WB_MEM;
      end
      S_MEM_WR: begin
        if (mem_ready) state_nxt = S_IF;
      end
      S_WB_ALU:  state_nxt = S_IF;
      S_WB_MEM:  state_nxt = S_IF;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IF;
    endcase
  end

  // An instruction retires when control returns to IF, or when it parks in HALT.
  assign retire = ((state_nxt == S_IF)   && (state != S_IF)) ||
                  ((state_nxt == S_HALT) && (state != S_HALT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IF;
      num_inst <= '0;
    end else begin
      state <= state_nxt;
      if (retire) num_inst <= num_inst + INST_CNT_W'(1);
    end
  end

  always_comb begin
    PCWrite      = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    ALUSrcA      = 1'b0;
    RegWrite     = 1'b0;
    MemtoReg     = 1'b0;
    isWWD        = 1'b0;
    is_halted    = 1'b0;
    PCSource     = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOperation = ALU_ADD;
    // Reset gates every strobe so an in-flight write cannot land during reset.
    if (!reset) begin
      case (state)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_ID: begin
          ALUSrcB = 2'b10;
          if (is_jmp) begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
          end
          isWWD = is_wwd;
        end
        S_EX_R: begin
          ALUSrcA = 1'b1;
        end
        S_EX_I: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = 2'b10;
          ALUOperation = is_lhi ? ALU_LHI : ALU_ADD;
        end
        S_EX_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_EX_BR: begin
          ALUSrcA      = 1'b1;
          ALUOperation = ALU_SUB;
          PCSource     = 2'b01;
          PCWrite      = bcond;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_WB_ALU: begin
          RegWrite = 1'b1;
          RegDst   = is_rtype;
        end
        S_WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_HALT: begin
          is_halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: each instruction expands to its list of phases, and every phase maps to the control word it must show.
module tb_multicycle_control;

  localparam int W = 4;

  typedef enum int {P_IF, P_ID, P_EXR, P_EXI, P_EXA, P_EXB, P_MRD, P_MWR, P_WBA, P_WBM, P_HALT} phase_t;

  typedef struct packed {
    logic pc_write, iord, mem_read, mem_write, ir_write, reg_dst, alu_src_a, reg_write, mem_to_reg, is_wwd, is_halted;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
  } ctrl_t;

  logic clk, reset, mem_ready, bcond;
  logic [3:0] opcode;
  logic [5:0] func_code;
  logic PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, ALUSrcA, RegWrite, MemtoReg, isWWD, is_halted;
  logic [1:0] PCSource, ALUSrcB;
  logic [3:0] ALUOperation;
  logic [W-1:0] num_inst;

  multicycle_control #(.INST_CNT_W(W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code),
    .mem_ready(mem_ready), .bcond(bcond),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .isWWD(isWWD), .is_halted(is_halted),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOperation(ALUOperation),
    .num_inst(num_inst)
  );

  ctrl_t dut_ctrl;
  assign dut_ctrl = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, ALUSrcA, RegWrite,
                     MemtoReg, isWWD, is_halted, PCSource, ALUSrcB, ALUOperation};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state, written only by the driver.
  phase_t       m_phase = P_IF;
  logic         chk_en = 1'b0;
  logic [W-1:0] exp_cnt = '0;
  logic         cnt_known = 1'b0;
  logic         inc_pending = 1'b0;
  logic         pin_cnt_en = 1'b0;
  int           pin_cnt_want = 0;
  logic         pin_diff_en = 1'b0;
  int           pin_diff_id = 0;
  int           pin_diff_got = 0;
  int           pin_diff_want = 0;
  logic [3:0]   cur_op = 4'd0;
  logic [5:0]   cur_fn = 6'd0;
  logic         cur_bc = 1'b0;
  int           snap [4];

  int checks = 0;
  int errors = 0;
  // Monitors: RegDst&RegWrite, MemRead&IorD, isWWD and is_halted cycles.
  int mon [4];

  function automatic ctrl_t expect_ctrl(input phase_t p, input logic [3:0] op, input logic [5:0] fn,
                                        input logic bc, input logic mr, input logic rst);
    ctrl_t c;
    c = '0;
    if (!rst) begin
      case (p)
        P_IF:   begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
        P_ID:   begin
                  c.alu_src_b = 2'b10;
                  if (op == 4'd9) begin c.pc_write = 1; c.pc_source = 2'b10; end
                  if (op == 4'd15 && fn == 6'd28) c.is_wwd = 1;
                end
        P_EXR:  c.alu_src_a = 1;
        P_EXI:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = (op == 4'd6) ? 4'd8 : 4'd0; end
        P_EXA:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
        P_EXB:  begin c.alu_src_a = 1; c.alu_op = 4'd1; c.pc_source = 2'b01; c.pc_write = bc; end
        P_MRD:  begin c.mem_read = 1; c.iord = 1; end
        P_MWR:  begin c.mem_write = 1; c.iord = 1; end
        P_WBA:  begin c.reg_write = 1; c.reg_dst = (op == 4'd15); end
        P_WBM:  begin c.reg_write = 1; c.mem_to_reg = 1; end
        P_HALT: c.is_halted = 1;
        default: ;
      endcase
    end
    return c;
  endfunction

  initial for (int k = 0; k < 4; k++) mon[k] = 0;

  always @(negedge clk) begin
    ctrl_t e;
    if (chk_en) begin
      e = expect_ctrl(m_phase, opcode, func_code, bcond, mem_ready, reset);
      checks++;
      if (dut_ctrl !== e) begin
        errors++;
        $display("FAIL ctrl t=%0t phase=%0d rst=%0b got=%h want=%h", $time, m_phase, reset, dut_ctrl, e);
      end
      if (cnt_known) begin
        checks++;
        if (num_inst !== exp_cnt) begin
          errors++;
          $display("FAIL num_inst t=%0t got=%0d want=%0d", $time, num_inst, exp_cnt);
        end
      end
      if (pin_cnt_en) begin
        checks++;
        if (int'(num_inst) != pin_cnt_want) begin
          errors++;
          $display("FAIL pin_num_inst t=%0t got=%0d want=%0d", $time, num_inst, pin_cnt_want);
        end
      end
      if (pin_diff_en) begin
        checks++;
        if (pin_diff_got != pin_diff_want) begin
          errors++;
          $display("FAIL pin_cycles[%0d] t=%0t got=%0d want=%0d", pin_diff_id, $time, pin_diff_got, pin_diff_want);
        end
      end
      if (RegDst && RegWrite) mon[0]++;
      if (MemRead && IorD)    mon[1]++;
      if (isWWD)              mon[2]++;
      if (is_halted)          mon[3]++;
    end
  end

  function automatic logic rb();
    return $urandom_range(1, 0) == 1;
  endfunction

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    if (reset) begin
      exp_cnt   = '0;
      cnt_known = 1'b1;
    end else if (inc_pending) begin
      exp_cnt = exp_cnt + 1'b1;
    end
    inc_pending = 1'b0;
    pin_cnt_en  = 1'b0;
    pin_diff_en = 1'b0;
  endtask

  task automatic step(input phase_t p, input logic mr, input logic last);
    begin_cycle();
    reset       = 1'b0;
    m_phase     = p;
    mem_ready   = mr;
    opcode      = cur_op;
    func_code   = cur_fn;
    bcond       = cur_bc;
    inc_pending = last;
    chk_en      = 1'b1;
  endtask

  task automatic rst_cycles(input int n);
    repeat (n) begin
      begin_cycle();
      reset     = 1'b1;
      mem_ready = rb();
      chk_en    = 1'b1;
    end
  endtask

  // cnt_want: num_inst before this instruction; sel/diff_want: monitor cycles since the previous run_instr.
  task automatic run_instr(input logic [3:0] op, input logic [5:0] fn, input logic bc,
                           input int if_wait, input int mem_wait,
                           input int cnt_want, input int sel, input int diff_want);
    cur_op = op; cur_fn = fn; cur_bc = bc;
    if (if_wait > 0) step(P_IF, 1'b0, 1'b0);
    else             step(P_IF, 1'b1, 1'b0);
    if (cnt_want >= 0) begin pin_cnt_en = 1'b1; pin_cnt_want = cnt_want; end
    if (sel >= 0) begin
      pin_diff_en = 1'b1; pin_diff_id = sel;
      pin_diff_got = mon[sel] - snap[sel]; pin_diff_want = diff_want;
    end
    for (int k = 0; k < 4; k++) snap[k] = mon[k];
    if (if_wait > 0) begin
      repeat (if_wait - 1) step(P_IF, 1'b0, 1'b0);
      step(P_IF, 1'b1, 1'b0);
    end
    if (op == 4'd15 && fn == 6'd0) begin
      step(P_ID, rb(), 0); step(P_EXR, rb(), 0); step(P_WBA, rb(), 1);
    end else if (op == 4'd4 || op == 4'd6) begin
      step(P_ID, rb(), 0); step(P_EXI, rb(), 0); step(P_WBA, rb(), 1);
    end else if (op == 4'd7) begin
      step(P_ID, rb(), 0); step(P_EXA, rb(), 0);
      repeat (mem_wait) step(P_MRD, 1'b0, 0);
      step(P_MRD, 1'b1, 0); step(P_WBM, rb(), 1);
    end else if (op == 4'd8) begin
      step(P_ID, rb(), 0); step(P_EXA, rb(), 0);
      repeat (mem_wait) step(P_MWR, 1'b0, 0);
      step(P_MWR, 1'b1, 1);
    end else if (op == 4'd0) begin
      step(P_ID, rb(), 0); step(P_EXB, rb(), 1);
    end else begin
      step(P_ID, rb(), 1);  // JMP, WWD, HLT (enters HALT) and NOPs
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; bcond = 1'b0; opcode = 4'd0; func_code = 6'd0;
    for (int k = 0; k < 4; k++) snap[k] = 0;

    rst_cycles(2);
    run_instr(4'd15, 6'd0,  0, 0, 0,  0, -1, 0);   // ADD
    run_instr(4'd7,  6'd0,  0, 0, 3,  1,  0, 1);   // LWD, 3 wait cycles; ADD wrote RegDst once
    run_instr(4'd4,  6'd0,  0, 2, 0,  2,  1, 4);   // ADI after IF stall; LWD held MemRead/IorD 4 cycles
    run_instr(4'd6,  6'd0,  0, 0, 0,  3, -1, 0);   // LHI
    run_instr(4'd8,  6'd0,  0, 1, 1, -1, -1, 0);   // SWD
    run_instr(4'd0,  6'd0,  1, 0, 0, -1, -1, 0);   // BNE taken
    run_instr(4'd0,  6'd0,  0, 0, 0, -1, -1, 0);   // BNE not taken
    run_instr(4'd9,  6'd0,  0, 0, 0, -1, -1, 0);   // JMP
    run_instr(4'd15, 6'd28, 0, 0, 0, -1, -1, 0);   // WWD
    run_instr(4'd15, 6'd5,  0, 0, 0,  9,  2, 1);   // NOP funct; WWD pulse exactly 1 cycle
    run_instr(4'd3,  6'd0,  0, 0, 0, -1, -1, 0);   // NOP opcode
    run_instr(4'd15, 6'd29, 0, 0, 0, 11, -1, 0);   // HLT
    repeat (20) step(P_HALT, rb(), 0);
    rst_cycles(2);
    run_instr(4'd9, 6'd0, 0, 0, 0, 0, 3, 20);      // halted for exactly 20 cycles, counter cleared

    // SWD aborted by reset while the write is still waiting on memory.
    cur_op = 4'd8; cur_fn = 6'd0; cur_bc = 1'b0;
    step(P_IF, 1'b1, 0); step(P_ID, rb(), 0); step(P_EXA, rb(), 0);
    step(P_MWR, 1'b0, 0); step(P_MWR, 1'b0, 0);
    begin_cycle();
    reset = 1'b1; mem_ready = 1'b0; chk_en = 1'b1;

    for (int i = 0; i <= 16; i++) run_instr(4'd9, 6'd0, 0, 0, 0, i % 16, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
